// File: rtl/deser8_if.sv
// Serial-in / byte-out stream bundle for deser8: bit input side, word output side
// and the partial-word bit counter.
interface deser8_if;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       out_any;
  logic [2:0] bit_count;

  // master: the environment that feeds bits and consumes words
  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_data, out_any, bit_count
  );

  // slave: the deserialiser itself
  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_data, out_any, bit_count
  );
endinterface

// File: rtl/deser8.sv
// 1-bit to 8-bit deserialiser with a one-word output buffer. While a finished word
// waits, bits 1..7 of the next word can still be collected in the shift register.
module deser8 #(
  parameter bit MSB_FIRST = 1'b1
) (
  input logic   clk,
  input logic   reset,
  deser8_if.slave bus
);

  logic [7:0] shreg_p0;
  logic [2:0] cnt_p0;
  logic [7:0] word_p1;
  logic       any_p1;
  logic       vld_p1;

  logic       in_rdy;
  logic       in_fire;
  logic       out_fire;
  logic       word_done;
  logic [7:0] shreg_nxt;

  // MSB-first shifts toward bit 7; LSB-first shifts toward bit 0.
  function automatic logic [7:0] insert_bit(input logic [7:0] cur, input logic b);
    if (MSB_FIRST) return {cur[6:0], b};
    else           return {b, cur[7:1]};
  endfunction

  // Only the 8th bit can be blocked, and only by a word that is not leaving now.
  assign in_rdy    = ~((cnt_p0 == 3'd7) & vld_p1 & ~bus.out_ready);
  assign in_fire   = bus.in_valid & in_rdy;
  assign out_fire  = vld_p1 & bus.out_ready;
  assign word_done = in_fire & (cnt_p0 == 3'd7);
  assign shreg_nxt = insert_bit(shreg_p0, bus.in_bit);

  // Stage p0: bit accumulation
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_p0 <= '0;
      cnt_p0   <= '0;
    end else if (in_fire) begin
      shreg_p0 <= shreg_nxt;
      cnt_p0   <= cnt_p0 + 3'd1;
    end
  end

  // Stage p1: completed word buffer; a word finishing on an output transfer replaces it
  always_ff @(posedge clk) begin
    if (reset) begin
      word_p1 <= '0;
      any_p1  <= 1'b0;
      vld_p1  <= 1'b0;
    end else if (word_done) begin
      word_p1 <= shreg_nxt;
      any_p1  <= |shreg_nxt;
      vld_p1  <= 1'b1;
    end else if (out_fire) begin
      any_p1  <= 1'b0;
      vld_p1  <= 1'b0;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld_p1;
  assign bus.out_data  = word_p1;
  assign bus.out_any   = any_p1;
  assign bus.bit_count = cnt_p0;

endmodule

// File: doc/deser8.md
DESER8 -- requirements
Module: deser8

Interface
REQ-001 Parameter MSB_FIRST, default 1, meaning: 1 = first accepted bit lands in out_data[7]; 0 = first accepted bit lands in out_data[0].
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 in_valid  input  1  serial bit present on in_bit this cycle.
REQ-005 in_bit  input  1  serial data bit.
REQ-006 in_ready  output  1  deser8 can accept in_bit this cycle.
REQ-007 out_valid  output  1  out_data holds a completed 8-bit word.
REQ-008 out_data  output  8  assembled word; stable while out_valid=1 and out_ready=0.
REQ-009 out_ready  input  1  consumer takes the word this cycle.
REQ-010 out_any  output  1  OR of all 8 out_data bits; 0 when out_valid=0.
REQ-011 bit_count  output  3  number of bits of the current partial word accepted so far (0..7).

Function
REQ-012 Bit transfer SHALL occur only on a cycle with in_valid=1 and in_ready=1; in_bit is ignored otherwise.
REQ-013 Output transfer SHALL occur only on a cycle with out_valid=1 and out_ready=1.
REQ-014 The shift register SHALL hold the partial word; bit_count SHALL increment by 1 per bit transfer and wrap 7->0 on the 8th bit.
REQ-015 MSB_FIRST=1: each transfer shifts left, inserting in_bit at bit 0, so the first bit ends in bit 7; MSB_FIRST=0: shift right, inserting at bit 7, so the first bit ends in bit 0.
REQ-016 On the 8th bit transfer, the completed word (including that bit) SHALL be loaded into out_data and out_valid SHALL be 1 on the next cycle; latency from 8th bit to out_valid = 1 cycle.
REQ-017 out_valid SHALL clear on the cycle after an output transfer, unless a new word completes in that same cycle, in which case out_valid SHALL stay 1 and out_data SHALL take the new word.
REQ-018 in_ready SHALL be 0 only when bit_count=7 and out_valid=1 and out_ready=0; it is 1 in all other cases, including reset-released idle.
REQ-019 Bits 1..7 of a following word SHALL be accepted while an earlier word waits in out_data (one word of buffering plus one partial word).
REQ-020 in_ready SHALL be combinational from out_ready; no other output SHALL combinationally depend on any input.
REQ-021 out_any SHALL be registered together with out_data (equals |out_data when out_valid=1).
REQ-022 Partial words are never emitted; bits stay in the shift register indefinitely until 8 are collected.
REQ-023 Gaps (in_valid=0) between bits SHALL not affect assembly or bit order.

Reset
REQ-024 While reset=1 at a rising edge: bit_count=0, shift register=0x00, out_data=0x00, out_valid=0, out_any=0 on the following cycle.
REQ-025 Reset SHALL take priority over any simultaneous bit or output transfer; a partial word and a pending output word are discarded.
REQ-026 in_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-027 MSB_FIRST=1, out_ready=1, bits 1,0,1,0,0,1,0,1 back-to-back -> one cycle after 8th bit out_valid=1, out_data=0xA5, out_any=1; next cycle out_valid=0.
REQ-028 MSB_FIRST=0, same bit sequence -> out_data=0xA5 reversed = 0xA5 palindrome check replaced by bits 1,0,0,0,0,0,0,0 -> out_data=0x01 (MSB_FIRST=1 gives 0x80).
REQ-029 Eight 0 bits -> out_valid=1, out_data=0x00, out_any=0; bit_count returns to 0.
REQ-030 out_ready=0, word 0x3C completed, then 7 bits of 0xFF sent -> in_ready=0 at bit_count=7, out_data holds 0x3C; raise out_ready with in_valid=1, in_bit=1 -> next cycle out_valid=1, out_data=0xFF.
REQ-031 in_valid toggled 1/0 every cycle while sending 0xC3 -> out_data=0xC3, no bit lost or duplicated.
REQ-032 Reset asserted after 5 bits and with a word pending -> next cycle out_valid=0, bit_count=0; fresh 8 bits produce the correct word.
